// File: rtl/bus_loader.sv
// Byte-stream bus initiator: host frames become single-word reads and writes on the CPU data bus.
// Optional feature: define BUS_LOADER_AUTOINC_EN for post-access address increment and the 0x4E write command.
module bus_loader #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_a,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd,
  output logic        frame_err,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Handshakes: a byte moves on a rising edge only when its valid and ready are both high.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_RESP,
    S_ERR
  } state_t;

  state_t          state, state_next;
  logic [1:0]      cnt;
  logic            is_write;
  logic [31:0]     addr_q;
  logic [23:0]     data_q;
  logic [31:0]     bus_a_q, bus_wd_q, resp_q;
  logic [TW-1:0]   tmo_cnt;
  logic            frame_err_q, frame_err_next;
  logic            collecting, accept, tx_fire, timeout_hit;
  logic            cmd_rd, cmd_wr, cmd_inc;
  logic [31:0]     addr_shift, data_shift;

  assign collecting = (state == S_ADDR) || (state == S_DATA);
  assign rx_ready   = (state == S_IDLE) || collecting;
  assign accept     = rx_valid && rx_ready;
  assign tx_valid   = (state == S_RESP) || (state == S_ERR);
  assign tx_fire    = tx_valid && tx_ready;
  assign bus_req    = (state == S_REQ);
  assign bus_we     = bus_req && bus_gnt && is_write;
  assign bus_a      = bus_a_q;
  assign bus_wd     = bus_wd_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state != S_IDLE);

  assign cmd_rd = (rx_data == 8'h52);
  assign cmd_wr = (rx_data == 8'h57);
`ifdef BUS_LOADER_AUTOINC_EN
  assign cmd_inc = (rx_data == 8'h4E);
`else
  assign cmd_inc = 1'b0;
`endif

  // Fields arrive MSB first, so each new byte shifts in at the bottom.
  assign addr_shift  = {addr_q[23:0], rx_data};
  assign data_shift  = {data_q, rx_data};
  assign timeout_hit = collecting && !accept && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_next     = state;
    frame_err_next = 1'b0;
    tx_data        = 8'h00;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_rd || cmd_wr) begin
            state_next = S_ADDR;
          end else if (cmd_inc) begin
            state_next = S_DATA;
          end else begin
            state_next     = S_ERR;
            frame_err_next = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (accept && (cnt == 2'd3)) begin
          state_next = is_write ? S_DATA : S_REQ;
        end else if (timeout_hit) begin
          state_next     = S_IDLE;
          frame_err_next = 1'b1;
        end
      end
      S_DATA: begin
        if (accept && (cnt == 2'd3)) begin
          state_next = S_REQ;
        end else if (timeout_hit) begin
          state_next     = S_IDLE;
          frame_err_next = 1'b1;
        end
      end
      S_REQ: begin
        if (bus_gnt) state_next = S_RESP;
      end
      S_RESP: begin
        if (is_write) begin
          tx_data = 8'h4B;
        end else begin
          case (cnt)
            2'd0:    tx_data = resp_q[31:24];
            2'd1:    tx_data = resp_q[23:16];
            2'd2:    tx_data = resp_q[15:8];
            default: tx_data = resp_q[7:0];
          endcase
        end
        if (tx_fire && (is_write || (cnt == 2'd3))) state_next = S_IDLE;
      end
      S_ERR: begin
        tx_data = 8'h3F;
        if (tx_fire) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 2'd0;
      is_write    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      bus_a_q     <= '0;
      bus_wd_q    <= '0;
      resp_q      <= '0;
      tmo_cnt     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_next;
      frame_err_q <= frame_err_next;

      // The byte counter restarts on every state change so each phase counts from 0.
      if (state_next != state) begin
        cnt <= 2'd0;
      end else if ((accept && collecting) || (tx_fire && (state == S_RESP))) begin
        cnt <= cnt + 2'd1;
      end

      if (accept || !collecting) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (accept && (state == S_IDLE)) begin
        is_write <= cmd_wr || cmd_inc;
      end

      // Bus address/data registers load on the edge that enters REQ, so they are stable for the access.
      if (accept && (state == S_ADDR)) begin
        addr_q <= addr_shift;
        if ((cnt == 2'd3) && !is_write) begin
          bus_a_q <= {addr_shift[31:2], 2'b00};
        end
      end

      if (accept && (state == S_DATA)) begin
        data_q <= data_shift[23:0];
        if (cnt == 2'd3) begin
          bus_a_q  <= {addr_q[31:2], 2'b00};
          bus_wd_q <= data_shift;
        end
      end

      if ((state == S_REQ) && bus_gnt) begin
        if (!is_write) resp_q <= bus_rd;
`ifdef BUS_LOADER_AUTOINC_EN
        addr_q <= {addr_q[31:2] + 30'd1, 2'b00};
`endif
      end
    end
  end

endmodule

// File: tb/tb_bus_loader.sv
// Scoreboard bench for bus_loader: frames are predicted by a word-level memory model, outputs checked by monitors.
// Build with BUS_LOADER_AUTOINC_EN defined to also cover the auto-increment write command.
module tb_bus_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [31:0] bus_a;
  logic [31:0] bus_wd;
  logic [31:0] bus_rd;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  bus_loader #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
    .bus_a(bus_a), .bus_wd(bus_wd), .bus_rd(bus_rd),
    .frame_err(frame_err), .busy(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int fe_count = 0;
  int exp_fe = 0;
  int fe_cyc = 0;
  int last_acc = 0;
  int mem_ver = 0;
  int tx_mode = 2;
  int gnt_mode = 0;
  int gap_max = 0;
  logic        fe_prev = 1'b0;
  logic        hold_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;
  logic [31:0] ref_addr = 32'h0;

  logic [7:0]  exp_q[$];
  logic [63:0] wr_q[$];
  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  localparam logic [79:0] RV = {2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};

  // Contents of never-written memory words, shared by the bus environment and the model.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [79:0] rv();
    return {2'b00, rx_ready, tx_valid, tx_data, bus_req, bus_we, bus_a, bus_wd, frame_err, busy};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 1) ? 32'h0000_0000 : 32'hFFFF_FF80;
    return base | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  always @(bus_a or mem_ver) bus_rd = env_mem.exists(bus_a) ? env_mem[bus_a] : init_val(bus_a);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tx_mode == 0) tx_ready = ($urandom_range(0, 1) == 1);
    else tx_ready = (tx_mode == 2);
    if (gnt_mode == 1) bus_gnt = ($urandom_range(0, 2) == 0);
    else bus_gnt = (gnt_mode == 0);
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: consumes expected tx bytes and bus writes whenever the DUT presents them.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
      fe_prev   = 1'b0;
    end else begin
      if (hold_prev && tx_valid) check("tx_stable", tx_data, data_prev);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tx_unexpected: actual %0h required no byte", tx_data);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
      end
      hold_prev = tx_valid && !tx_ready;
      data_prev = tx_data;
      if (bus_we) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL bus_write_unexpected: actual %0h/%0h required no write", bus_a, bus_wd);
        end else begin
          check("bus_write", {bus_a, bus_wd}, wr_q.pop_front());
        end
        env_mem[bus_a] = bus_wd;
        mem_ver++;
      end
      if (frame_err) begin
        fe_count++;
        fe_cyc = cyc;
        if (fe_prev) begin
          n_cmp++; n_fail++;
          $display("FAIL frame_err_width: actual 2+ cycles required 1");
        end
      end
      fe_prev = frame_err;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) fail_now("rx_accept");
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    last_acc = cyc;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    ref_mem[wa] = d;
    wr_q.push_back({wa, d});
    exp_q.push_back(8'h4B);
`ifdef BUS_LOADER_AUTOINC_EN
    ref_addr = wa + 32'd4;
`endif
    send_byte(8'h57);
    send_word(a);
    send_word(d);
  endtask

  task automatic send_read(input logic [31:0] a);
    logic [31:0] wa, v;
    wa = a & 32'hFFFF_FFFC;
    v  = ref_mem.exists(wa) ? ref_mem[wa] : init_val(wa);
    exp_q.push_back(v[31:24]);
    exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
`ifdef BUS_LOADER_AUTOINC_EN
    ref_addr = wa + 32'd4;
`endif
    send_byte(8'h52);
    send_word(a);
  endtask

  task automatic send_unknown(input logic [7:0] b);
    exp_q.push_back(8'h3F);
    exp_fe++;
    send_byte(b);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (busy || exp_q.size() != 0) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(name, rv(), RV);
    exp_q.delete();
    ref_addr = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int t0;
    logic [7:0] b;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    mem_ver = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", rv(), RV);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_release", rv(), RV);
    @(posedge clk);
    #1;

    // Write with grant already high: access one cycle after the last byte, ack the cycle after.
    send_write(32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wr_access", {bus_req, bus_we, bus_a, bus_wd}, {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF});
    @(negedge clk);
    check("wr_tx_latency", tx_valid, 1'b1);
    wait_done("wr_done");

    // Read with unaligned host address and a randomly stalling host.
    env_mem[32'h10] = 32'h1234_5678;
    ref_mem[32'h10] = 32'h1234_5678;
    mem_ver++;
    tx_mode = 0;
    send_read(32'h0000_0013);
    @(negedge clk);
    check("rd_access", {bus_req, bus_a}, {1'b1, 32'h10});
    wait_done("rd_done");

    // Grant withheld for 20 cycles.
    gnt_mode = 2;
    tx_mode = 2;
    send_write(32'h0000_0040, $urandom());
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("gnt_wait", {bus_req, bus_we}, 2'b10);
    end
    gnt_mode = 0;
    @(negedge clk);
    check("gnt_access", {bus_req, bus_we}, 2'b11);
    wait_done("gnt_done");

    // Stalled frame times out after 255 idle cycles with no response.
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    t0 = last_acc;
    exp_fe++;
    n = 0;
    @(negedge clk);
    while (!frame_err && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!frame_err) begin
      fail_now("timeout_pulse");
    end else begin
      check("timeout_cycles", cyc - t0, 255);
      check("timeout_idle", {busy, tx_valid}, 2'b00);
    end
    @(posedge clk);
    #1;
    send_read(rand_addr());
    wait_done("after_timeout");

    send_unknown(8'h99);
    wait_done("unknown_cmd");

`ifdef BUS_LOADER_AUTOINC_EN
    send_write(32'h0000_0020, $urandom());
    wait_done("autoinc_first");
    begin
      logic [31:0] d2;
      d2 = $urandom();
      ref_mem[ref_addr] = d2;
      wr_q.push_back({ref_addr, d2});
      exp_q.push_back(8'h4B);
      ref_addr = ref_addr + 32'd4;
      send_byte(8'h4E);
      send_word(d2);
    end
    wait_done("autoinc_second");
`else
    send_unknown(8'h4E);
    wait_done("no_autoinc_cmd");
`endif

    // Reset in the middle of the address bytes, then in RESP with the host stalled.
    send_byte(8'h52);
    send_byte(8'h00);
    pulse_reset("rst_mid_addr");
    tx_mode = 1;
    send_read(rand_addr());
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!tx_valid) fail_now("resp_reach");
    pulse_reset("rst_in_resp");
    tx_mode = 0;
    send_read(32'h0000_0010);
    wait_done("after_reset");

    // Randomized frames with random gaps, grant and host back-pressure.
    gap_max = 2;
    gnt_mode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: send_write(rand_addr(), $urandom());
        3, 4:    send_read(rand_addr());
        default: begin
          b = 8'($urandom_range(0, 255));
          while (b == 8'h52 || b == 8'h57 || b == 8'h4E) b = 8'($urandom_range(0, 255));
          send_unknown(b);
        end
      endcase
      wait_done("rand_frame");
    end

    repeat (4) @(negedge clk);
    check("tx_queue_empty", exp_q.size(), 0);
    check("wr_queue_empty", wr_q.size(), 0);
    check("frame_err_count", fe_count, exp_fe);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
